// File: rtl/exec_sequencer.sv
// Issue/sequencing controller for the execute datapath: accepts one op, times its class latency,
// captures the result and holds it for writeback. Optional perf counters under EXEC_SEQ_PERF_EN.
module exec_sequencer #(
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_CLASS,
    input  logic [4:0]       IN_RD,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             EX_START,
    output logic [1:0]       EX_CLASS,
    output logic             EX_ABORT,
    input  logic [31:0]      EX_RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [4:0]       OUT_RD,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic [31:0]      OUT_RESULT,
    input  logic             FLUSH,
    output logic             BUSY
`ifdef EXEC_SEQ_PERF_EN
    ,
    output logic [31:0]      PERF_BUSY_CYC,
    output logic [31:0]      PERF_STALL_CYC
`endif
);

    localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ((ALU_LAT > DIV_LAT) ? ALU_LAT : DIV_LAT)
                                                 : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         rd_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         cls_q;
    logic               out_valid_q;
    logic [4:0]         out_rd_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [31:0]        out_result_q;
    logic               accept;

    // Reserved class 3 falls through to the ALU latency.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] cls);
        case (cls)
            2'd1:    return CNT_W'(MUL_LAT - 1);
            2'd2:    return CNT_W'(DIV_LAT - 1);
            default: return CNT_W'(ALU_LAT - 1);
        endcase
    endfunction

    assign IN_READY   = !RST && !FLUSH &&
                        ((state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY));
    assign accept     = IN_VALID && IN_READY;
    assign EX_START   = accept;
    assign EX_CLASS   = accept ? IN_CLASS : cls_q;
    assign EX_ABORT   = !RST && FLUSH && (state_q == S_WAIT);
    assign BUSY       = (state_q != S_IDLE);
    assign OUT_VALID  = out_valid_q;
    assign OUT_RD     = out_rd_q;
    assign OUT_TAG    = out_tag_q;
    assign OUT_RESULT = out_result_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            tag_q        <= '0;
            cls_q        <= '0;
            out_valid_q  <= 1'b0;
            out_rd_q     <= '0;
            out_tag_q    <= '0;
            out_result_q <= '0;
        end else if (FLUSH) begin
            // Held result is dropped; OUT_RESULT keeps its stale value.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            rd_q        <= IN_RD;
            tag_q       <= IN_TAG;
            cls_q       <= IN_CLASS;
            cnt_q       <= lat_m1(IN_CLASS);
            out_valid_q <= 1'b0;
            state_q     <= S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        out_result_q <= EX_RESULT;
                        out_rd_q     <= rd_q;
                        out_tag_q    <= tag_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef EXEC_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == S_WAIT)
                perf_busy_q <= perf_busy_q + 32'd1;
            if (out_valid_q && !OUT_READY)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign PERF_BUSY_CYC  = perf_busy_q;
    assign PERF_STALL_CYC = perf_stall_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a cycle-level reference model predicts handshakes and
// pushes expected writebacks; an independent monitor pops and compares on every OUT_VALID.
module tb_exec_sequencer;

    localparam int TAG_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [1:0]       IN_CLASS = '0;
    logic [4:0]       IN_RD = '0;
    logic [TAG_W-1:0] IN_TAG = '0;
    logic             EX_START;
    logic [1:0]       EX_CLASS;
    logic             EX_ABORT;
    logic [31:0]      EX_RESULT = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [4:0]       OUT_RD;
    logic [TAG_W-1:0] OUT_TAG;
    logic [31:0]      OUT_RESULT;
    logic             FLUSH = 1'b0;
    logic             BUSY;
`ifdef EXEC_SEQ_PERF_EN
    logic [31:0]      PERF_BUSY_CYC;
    logic [31:0]      PERF_STALL_CYC;
`endif

    exec_sequencer #(.TAG_W(TAG_W), .ALU_LAT(1), .MUL_LAT(3), .DIV_LAT(34)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CLASS(IN_CLASS),
        .IN_RD(IN_RD), .IN_TAG(IN_TAG),
        .EX_START(EX_START), .EX_CLASS(EX_CLASS), .EX_ABORT(EX_ABORT),
        .EX_RESULT(EX_RESULT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RD(OUT_RD),
        .OUT_TAG(OUT_TAG), .OUT_RESULT(OUT_RESULT),
        .FLUSH(FLUSH), .BUSY(BUSY)
`ifdef EXEC_SEQ_PERF_EN
        , .PERF_BUSY_CYC(PERF_BUSY_CYC), .PERF_STALL_CYC(PERF_STALL_CYC)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // Reference model: an op is either in flight until a known cycle, held, or absent.
    logic        m_inflight = 1'b0;
    logic        m_held     = 1'b0;
    int          m_due      = 0;
    logic [1:0]  m_cls      = '0;
    logic [31:0] m_busy     = '0;
    logic [31:0] m_stall    = '0;

    function automatic logic [31:0] resf(input int n);
        logic [31:0] u;
        u = 32'(n);
        return (u * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int lat_of(input logic [1:0] c);
        return (c == 2'd1) ? 3 : (c == 2'd2) ? 34 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus, followed by control-signal checks and the model's edge update.
    task automatic step(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                        input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                        input logic rs);
        logic e_rdy, e_start;
        exp_t e;
        @(posedge CLK); #1;
        cyc++;
        IN_VALID = v; IN_CLASS = cls; IN_RD = rd; IN_TAG = tag;
        OUT_READY = ordy; FLUSH = fl; RST = rs; EX_RESULT = resf(cyc);
        @(negedge CLK); #1;
        e_rdy   = !rs && !fl && ((!m_inflight && !m_held) || (m_held && ordy));
        e_start = v && e_rdy;
        chk("in_ready",  IN_READY,  e_rdy);
        chk("ex_start",  EX_START,  e_start);
        chk("ex_abort",  EX_ABORT,  !rs && fl && m_inflight);
        chk("busy",      BUSY,      m_inflight || m_held);
        chk("out_valid", OUT_VALID, m_held);
        if (e_start)
            chk("ex_class", EX_CLASS, cls);
        else if (m_inflight || m_held)
            chk("ex_class_hold", EX_CLASS, m_cls);
`ifdef EXEC_SEQ_PERF_EN
        chk("perf_busy",  PERF_BUSY_CYC,  m_busy);
        chk("perf_stall", PERF_STALL_CYC, m_stall);
`endif
        if (rs) begin
            m_busy = '0; m_stall = '0;
        end else begin
            if (m_inflight) m_busy = m_busy + 32'd1;
            if (m_held && !ordy) m_stall = m_stall + 32'd1;
        end
        if (rs) begin
            m_inflight = 1'b0; m_held = 1'b0; m_cls = '0;
            sbq.delete();
        end else if (fl) begin
            if (m_inflight || m_held) void'(sbq.pop_back());
            m_inflight = 1'b0; m_held = 1'b0;
        end else if (e_start) begin
            e.rd = rd; e.tag = tag; e.res = resf(cyc + lat_of(cls));
            sbq.push_back(e);
            m_inflight = 1'b1; m_held = 1'b0; m_cls = cls;
            m_due = cyc + lat_of(cls);
        end else if (m_held && ordy) begin
            m_held = 1'b0;
        end else if (m_inflight && cyc == m_due) begin
            m_inflight = 1'b0; m_held = 1'b1;
        end
    endtask

    // Monitor: compares every presented writeback against the scoreboard head.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out cyc=%0d actual=valid required=no_result", cyc);
            end else begin
                checks--;
                chk("out_rd",     OUT_RD,     sbq[0].rd);
                chk("out_tag",    OUT_TAG,    sbq[0].tag);
                chk("out_result", OUT_RESULT, sbq[0].res);
                if (OUT_READY && !FLUSH) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        // Reset held with a valid op presented
        step(1, 2'd0, 5'd1, 4'd1, 1, 0, 1);
        step(1, 2'd0, 5'd1, 4'd1, 1, 0, 1);
        step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        // Single ALU op
        step(1, 2'd0, 5'd5, 4'd3, 1, 0, 0);
        repeat (3) step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        // DIV with writeback backpressure, decode still presenting ops
        step(1, 2'd2, 5'd9, 4'd7, 0, 0, 0);
        repeat (34) step(0, 2'd0, 5'd0, 4'd0, 0, 0, 0);
        repeat (5) step(1, 2'd0, 5'd2, 4'd2, 0, 0, 0);
        step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        // Back-to-back ALU stream with writeback always ready
        for (int i = 0; i < 16; i++)
            step(1, 2'(i % 2 == 0 ? 0 : 3), 5'(i + 10), 4'(i), 1, 0, 0);
        repeat (2) step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        // Flush a MUL one edge before its result, then an ALU op completes
        step(1, 2'd1, 5'd20, 4'd9, 1, 0, 0);
        step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        step(0, 2'd0, 5'd0, 4'd0, 0, 1, 0);
        step(1, 2'd0, 5'd21, 4'd10, 1, 0, 0);
        repeat (3) step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        // Flush while a result is held, and flush while idle
        step(1, 2'd1, 5'd22, 4'd11, 0, 0, 0);
        repeat (4) step(0, 2'd0, 5'd0, 4'd0, 0, 0, 0);
        step(0, 2'd0, 5'd0, 4'd0, 0, 1, 0);
        step(0, 2'd0, 5'd0, 4'd0, 0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic fl, ordy;
            fl   = ($urandom_range(0, 24) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                 ordy, fl, ($urandom_range(0, 299) == 0));
        end
        // Drain
        repeat (40) step(0, 2'd0, 5'd0, 4'd0, 1, 0, 0);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
